// File: rtl/timer_pkg.sv
// Shared state encoding and helpers for the countdown timer.
// Holds the FSM state type and the prescaler width helper.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNTING = 2'd1,
      PAUSED   = 2'd2,
      EXPIRED  = 2'd3
   } state_t;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COUNTING = 2'd1;
   localparam logic [1:0] ST_PAUSED   = 2'd2;
   localparam logic [1:0] ST_EXPIRED  = 2'd3;

   // Bits needed to hold 0 .. p-1 (at least one bit).
   function automatic int presc_width(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle tick strobes every PRESCALE cycles.
// Ports: clock, reset (async, active-low), enable, clear -> tick.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int PW = presc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q;

   // Tick is combinational on the held phase so the top level can act
   // on it in the same cycle the phase reaches its last value.
   assign tick = enable && (cnt_q == LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         if (cnt_q == LAST)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause/resume and optional auto-reload.
// Ports: clock, reset (async, active-low), load, load_value, go, pause
//        -> count, start (level in EXPIRED), done (expiry pulse), state.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int INIT        = 5,
   parameter int PRESCALE    = 1,
   parameter bit AUTO_START  = 1'b1,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             go,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             start,
   output logic             done,
   output logic [1:0]       state
);

   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
   localparam state_t RST_STATE = AUTO_START ? COUNTING : IDLE;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             start_q, start_d;

   logic presc_en;
   logic presc_clr;
   logic tick;
   logic go_eff;
   logic expire;

   // pause always wins over go.
   assign go_eff = go && !pause;

   assign presc_en = (state_q == COUNTING) && !load && !pause;

   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_presc (
      .clock (clock),
      .reset (reset),
      .enable(presc_en),
      .clear (presc_clr),
      .tick  (tick)
   );

   // A zero count in COUNTING expires at once, without waiting a tick.
   assign expire = (count_q == '0) ||
                   (tick && (count_q == WIDTH'(1)));

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      done_d    = 1'b0;
      presc_clr = 1'b0;

      if (load) begin
         count_d   = load_value;
         reload_d  = load_value;
         presc_clr = 1'b1;
         state_d   = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (go_eff) begin
                  state_d   = COUNTING;
                  presc_clr = 1'b1;
               end
            end
            COUNTING: begin
               if (pause) begin
                  state_d = PAUSED;
               end else if (expire) begin
                  done_d = 1'b1;
                  // Reload of zero would pulse forever; treat as one-shot.
                  if (AUTO_RELOAD && (reload_q != '0)) begin
                     count_d = reload_q;
                  end else begin
                     count_d   = '0;
                     state_d   = EXPIRED;
                     presc_clr = 1'b1;
                  end
               end else if (tick) begin
                  count_d = count_q - WIDTH'(1);
               end
            end
            PAUSED: begin
               if (go_eff)
                  state_d = COUNTING;
            end
            EXPIRED: begin
               if (go_eff) begin
                  state_d   = COUNTING;
                  count_d   = reload_q;
                  presc_clr = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      start_d = (state_d == EXPIRED);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= RST_STATE;
         count_q  <= INIT_V;
         reload_q <= INIT_V;
         done_q   <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
         start_q  <= start_d;
      end
   end

   assign count = count_q;
   assign start = start_q;
   assign done  = done_q;
   assign state = state_q;

endmodule
